// File: rtl/als_display_formatter_pkg.sv
// Shared types and helpers for the ALS display formatter: digit/state types
// and the packing of three BCD digits into the display word.
package als_display_formatter_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ACCUM,
    CONVERT,
    PUBLISH
  } fmt_state_t;

  localparam int DISPLAY_DIGITS = 8;
  localparam int BCD_ITERATIONS = 8;

  // Upper digits are always unlit; hundreds/tens blank only while they are leading zeros.
  function automatic logic [DISPLAY_DIGITS*4-1:0] pack_display(
    input bcd_digit_t hundreds,
    input bcd_digit_t tens,
    input bcd_digit_t ones,
    input bcd_digit_t blank_code,
    input logic       zero_blank
  );
    bcd_digit_t hd;
    bcd_digit_t td;
    hd = hundreds;
    td = tens;
    if (zero_blank && (hundreds == 4'd0)) begin
      hd = blank_code;
      if (tens == 4'd0) begin
        td = blank_code;
      end
    end
    return {{(DISPLAY_DIGITS-3){blank_code}}, hd, td, ones};
  endfunction

endpackage

// File: rtl/als_display_formatter_bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (double-dabble),
// one add-3/shift step per clock, eight steps per conversion.
module bcd_double_dabble_8
  import als_display_formatter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] bin_i,
  output logic       done_o,
  output bcd_digit_t hundreds_o,
  output bcd_digit_t tens_o,
  output bcd_digit_t ones_o
);

  logic [19:0] shift_q;
  logic [19:0] adj;
  logic [2:0]  iter_q;
  logic        running_q;

  // done_o marks the cycle whose closing edge performs the final step.
  assign done_o = running_q && (iter_q == 3'(BCD_ITERATIONS - 1));

  always_comb begin
    adj = shift_q;
    if (shift_q[19:16] >= 4'd5) adj[19:16] = shift_q[19:16] + 4'd3;
    if (shift_q[15:12] >= 4'd5) adj[15:12] = shift_q[15:12] + 4'd3;
    if (shift_q[11:8]  >= 4'd5) adj[11:8]  = shift_q[11:8]  + 4'd3;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shift_q   <= '0;
      iter_q    <= '0;
      running_q <= 1'b0;
    end else if (start_i) begin
      shift_q   <= {12'd0, bin_i};
      iter_q    <= '0;
      running_q <= 1'b1;
    end else if (running_q) begin
      shift_q <= {adj[18:0], 1'b0};
      iter_q  <= iter_q + 3'd1;
      if (done_o) begin
        running_q <= 1'b0;
      end
    end
  end

  assign hundreds_o = shift_q[19:16];
  assign tens_o     = shift_q[15:12];
  assign ones_o     = shift_q[11:8];

endmodule

// File: rtl/als_display_formatter.sv
// Averages 2^AVG_LOG2 ALS readings, converts the mean to BCD and publishes a
// nibble-packed word for the seven-segment display controller.
module als_display_formatter
  import als_display_formatter_pkg::*;
#(
  parameter int         AVG_LOG2           = 2,
  parameter bcd_digit_t BLANK_CODE         = 4'hF,
  parameter bit         LEADING_ZERO_BLANK = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [7:0]                  sample_i,
  input  logic                        sample_valid_i,
  output logic [DISPLAY_DIGITS*4-1:0] display_o,
  output logic                        display_valid_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DISPLAY_DIGITS*4-1:0] DISPLAY_RESET =
    {{(DISPLAY_DIGITS-1){BLANK_CODE}}, 4'h0};

  fmt_state_t       state_q;
  fmt_state_t       state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last_sample;
  logic             conv_start;
  logic             conv_done;
  logic [7:0]       avg;
  bcd_digit_t       hundreds;
  bcd_digit_t       tens;
  bcd_digit_t       ones;

  assign acc_sum     = acc_q + ACC_W'(sample_i);
  assign avg         = acc_sum[AVG_LOG2 +: 8];
  assign last_sample = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (sample_valid_i && last_sample) state_d = CONVERT;
      CONVERT: if (conv_done) state_d = PUBLISH;
      PUBLISH: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != ACCUM);
    accept     = (state_q == ACCUM) && sample_valid_i;
    conv_start = accept && last_sample;
  end

  // Samples arriving while busy are dropped outright and only flag the overrun.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q           <= '0;
      cnt_q           <= '0;
      display_o       <= DISPLAY_RESET;
      display_valid_o <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      display_valid_o <= 1'b0;
      if (sample_valid_i && busy_o) begin
        overrun_o <= 1'b1;
      end
      if (accept) begin
        if (last_sample) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (state_q == PUBLISH) begin
        display_o       <= pack_display(hundreds, tens, ones, BLANK_CODE, LEADING_ZERO_BLANK);
        display_valid_o <= 1'b1;
      end
    end
  end

  bcd_double_dabble_8 u_bcd (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (conv_start),
    .bin_i      (avg),
    .done_o     (conv_done),
    .hundreds_o (hundreds),
    .tens_o     (tens),
    .ones_o     (ones)
  );

endmodule

// File: tb/tb_als_display_formatter.sv
// Scoreboard bench: three formatter instances (averaging, raw, raw without
// zero blanking) share clock and reset; monitors pop expected words on each pulse.
module tb_als_display_formatter;

  localparam int AVG = 0;
  localparam int RAW = 1;
  localparam int NZ  = 2;

  typedef struct packed {
    logic [31:0] disp;
    logic [31:0] due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_avg, s_raw, s_nz;
  logic        v_avg, v_raw, v_nz;
  logic [31:0] d_avg, d_raw, d_nz;
  logic        dv_avg, dv_raw, dv_nz;
  logic        b_avg, b_raw, b_nz;
  logic        o_avg, o_raw, o_nz;

  exp_t q_avg[$];
  exp_t q_raw[$];
  exp_t q_nz[$];

  int vectors;
  int miscompares;
  int cyc;

  als_display_formatter #(.AVG_LOG2(2), .BLANK_CODE(4'hF), .LEADING_ZERO_BLANK(1'b1)) u_avg (
    .clk_i(clk), .rst_i(rst_n), .sample_i(s_avg), .sample_valid_i(v_avg),
    .display_o(d_avg), .display_valid_o(dv_avg), .busy_o(b_avg), .overrun_o(o_avg)
  );

  als_display_formatter #(.AVG_LOG2(0), .BLANK_CODE(4'hF), .LEADING_ZERO_BLANK(1'b1)) u_raw (
    .clk_i(clk), .rst_i(rst_n), .sample_i(s_raw), .sample_valid_i(v_raw),
    .display_o(d_raw), .display_valid_o(dv_raw), .busy_o(b_raw), .overrun_o(o_raw)
  );

  als_display_formatter #(.AVG_LOG2(0), .BLANK_CODE(4'hF), .LEADING_ZERO_BLANK(1'b0)) u_nz (
    .clk_i(clk), .rst_i(rst_n), .sample_i(s_nz), .sample_valid_i(v_nz),
    .display_o(d_nz), .display_valid_o(dv_nz), .busy_o(b_nz), .overrun_o(o_nz)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_pack(input int v, input bit lzb);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    if (lzb && h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
    return {20'hFFFFF, h, t, o};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveSample(input int dut, input logic [7:0] s, input logic [31:0] expd, input bit expect_out);
    exp_t e;
    e = {expd, 32'(cyc + 10)};
    case (dut)
      AVG: begin s_avg = s; v_avg = 1'b1; if (expect_out) q_avg.push_back(e); end
      RAW: begin s_raw = s; v_raw = 1'b1; if (expect_out) q_raw.push_back(e); end
      default: begin s_nz = s; v_nz = 1'b1; if (expect_out) q_nz.push_back(e); end
    endcase
  endtask

  task automatic clearStrobes();
    v_avg = 1'b0;
    v_raw = 1'b0;
    v_nz  = 1'b0;
  endtask

  task automatic applyStimulus(input int dut, input logic [7:0] s, input logic [31:0] expd, input bit expect_out);
    driveSample(dut, s, expd, expect_out);
    tick();
    clearStrobes();
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((b_avg || b_raw || b_nz || q_avg.size() > 0 || q_raw.size() > 0 || q_nz.size() > 0) && n < 40) begin
      tick();
      n++;
    end
    checkOutput("idle within budget", 32'(n < 40), 32'd1);
  endtask

  task automatic checkPulse(input int dut, input logic [31:0] disp, input string tag);
    exp_t e;
    bit   have;
    have = 1'b0;
    e = '0;
    case (dut)
      AVG: if (q_avg.size() > 0) begin e = q_avg.pop_front(); have = 1'b1; end
      RAW: if (q_raw.size() > 0) begin e = q_raw.pop_front(); have = 1'b1; end
      default: if (q_nz.size() > 0) begin e = q_nz.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checkOutput({tag, " pulse was expected"}, 32'(have), 32'd1);
    end else begin
      checkOutput({tag, " display"}, disp, e.disp);
      checkOutput({tag, " latency"}, 32'(cyc), e.due);
    end
  endtask

  always @(negedge clk) if (dv_avg) checkPulse(AVG, d_avg, "avg");
  always @(negedge clk) if (dv_raw) checkPulse(RAW, d_raw, "raw");
  always @(negedge clk) if (dv_nz)  checkPulse(NZ,  d_nz,  "nz");

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    s_avg = '0; s_raw = '0; s_nz = '0;
    clearStrobes();
    repeat (3) tick();

    checkOutput("reset display avg", d_avg, 32'hFFFF_FFF0);
    checkOutput("reset display raw", d_raw, 32'hFFFF_FFF0);
    checkOutput("reset display nz",  d_nz,  32'hFFFF_FFF0);
    checkOutput("reset flags avg", {29'd0, dv_avg, b_avg, o_avg}, 32'd0);
    checkOutput("reset flags raw", {29'd0, dv_raw, b_raw, o_raw}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Four-sample average: 101 / 4 truncates to 25.
    applyStimulus(AVG, 8'd10, 32'h0, 1'b0);
    applyStimulus(AVG, 8'd20, 32'h0, 1'b0);
    applyStimulus(AVG, 8'd30, 32'h0, 1'b0);
    checkOutput("avg not busy mid-set", 32'(b_avg), 32'd0);
    applyStimulus(AVG, 8'd41, 32'hFFFF_FF25, 1'b1);
    checkOutput("avg busy after last", 32'(b_avg), 32'd1);
    waitIdle();

    applyStimulus(RAW, 8'd255, 32'hFFFF_F255, 1'b1);
    waitIdle();
    applyStimulus(RAW, 8'd0, 32'hFFFF_FFF0, 1'b1);
    waitIdle();
    applyStimulus(RAW, 8'd100, 32'hFFFF_F100, 1'b1);
    waitIdle();
    applyStimulus(RAW, 8'd5, 32'hFFFF_FFF5, 1'b1);
    waitIdle();
    applyStimulus(RAW, 8'd10, 32'hFFFF_FF10, 1'b1);
    waitIdle();
    applyStimulus(NZ, 8'd7, 32'hFFFF_F007, 1'b1);
    waitIdle();

    // Overrun: 99 lands while busy and must never appear.
    checkOutput("raw overrun clear", 32'(o_raw), 32'd0);
    applyStimulus(RAW, 8'd50, 32'hFFFF_FF50, 1'b1);
    repeat (2) tick();
    applyStimulus(RAW, 8'd99, 32'h0, 1'b0);
    checkOutput("raw overrun set", 32'(o_raw), 32'd1);
    waitIdle();
    applyStimulus(RAW, 8'd12, 32'hFFFF_FF12, 1'b1);
    waitIdle();
    checkOutput("raw overrun sticky", 32'(o_raw), 32'd1);

    // A strobe on the edge leaving PUBLISH is dropped.
    applyStimulus(NZ, 8'd2, 32'hFFFF_F002, 1'b1);
    repeat (8) tick();
    checkOutput("nz busy before publish edge", 32'(b_nz), 32'd1);
    applyStimulus(NZ, 8'd3, 32'h0, 1'b0);
    checkOutput("nz overrun on publish edge", 32'(o_nz), 32'd1);
    checkOutput("nz idle after publish", 32'(b_nz), 32'd0);
    applyStimulus(NZ, 8'd4, 32'hFFFF_F004, 1'b1);
    waitIdle();

    // Reset four cycles into a conversion aborts it silently.
    repeat (4) applyStimulus(AVG, 8'd40, 32'h0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("abort display avg", d_avg, 32'hFFFF_FFF0);
    checkOutput("abort flags avg", {29'd0, dv_avg, b_avg, o_avg}, 32'd0);
    checkOutput("abort clears overrun raw", 32'(o_raw), 32'd0);
    rst_n = 1'b1;
    repeat (12) tick();
    checkOutput("abort display held", d_avg, 32'hFFFF_FFF0);

    applyStimulus(AVG, 8'd8, 32'h0, 1'b0);
    applyStimulus(AVG, 8'd9, 32'h0, 1'b0);
    applyStimulus(AVG, 8'd10, 32'h0, 1'b0);
    applyStimulus(AVG, 8'd11, 32'hFFFF_FFF9, 1'b1);
    waitIdle();
    checkOutput("avg display held", d_avg, 32'hFFFF_FFF9);
    repeat (4) applyStimulus(AVG, 8'd255, 32'h0, 1'b0);
    q_avg.push_back({32'hFFFF_F255, 32'(cyc + 9)});
    waitIdle();

    for (int v = 0; v < 256; v++) begin
      driveSample(RAW, 8'(v), ref_pack(v, 1'b1), 1'b1);
      driveSample(NZ,  8'(v), ref_pack(v, 1'b0), 1'b1);
      tick();
      clearStrobes();
      repeat (9) tick();
    end
    waitIdle();

    checkOutput("avg queue drained", 32'(q_avg.size()), 32'd0);
    checkOutput("raw queue drained", 32'(q_raw.size()), 32'd0);
    checkOutput("nz queue drained",  32'(q_nz.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
